// File: rtl/pmcc_matrix_sequencer.sv
// Matrix control word register for the PMC coprocessor. It supports write, set and clear
// commands, and includes an autonomous clkSh pulse-train generator.
module pmcc_matrix_sequencer #(
  parameter int CTRL_W     = 16,
  parameter int CLK_SH_BIT = 0,
  parameter int CNT_W      = 8,
  parameter int DIV_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmcc_rst,
  input  logic              store,
  input  logic [31:0]       instr,
  output logic [CTRL_W-1:0] ctrl_word,
  output logic              busy,
  output logic              done,
  output logic              cmd_dropped
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_PULSE = 2'b11;

  state_e             state_q, state_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [DIV_W-1:0]   halfCnt_q, halfCnt_d;
  logic [DIV_W-1:0]   halfReload_q, halfReload_d;
  logic [CNT_W-1:0]   pulseCnt_q, pulseCnt_d;
  logic               done_q, done_d;
  logic               dropped_q, dropped_d;

  logic [1:0]         opcode;
  logic [CTRL_W-1:0]  dataField;
  logic [CNT_W-1:0]   pulseField;
  logic [DIV_W-1:0]   halfField;
  logic               unused_instr;

  assign opcode       = instr[31:30];
  assign dataField    = instr[8 +: CTRL_W];
  assign pulseField   = instr[8 +: CNT_W];
  // The half-period field already equals H-1, which is exactly the counter reload value.
  assign halfField    = instr[8+CNT_W +: DIV_W];
  assign unused_instr = ^instr;

  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    halfCnt_d    = halfCnt_q;
    halfReload_d = halfReload_q;
    pulseCnt_d   = pulseCnt_q;
    done_d       = 1'b0;
    dropped_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (store) begin
          unique case (opcode)
            OP_WRITE: ctrl_d = dataField;
            OP_SET:   ctrl_d = ctrl_q | dataField;
            OP_CLEAR: ctrl_d = ctrl_q & ~dataField;
            OP_PULSE: begin
              if (pulseField != '0) begin
                state_d            = HIGH;
                ctrl_d[CLK_SH_BIT] = 1'b1;
                halfCnt_d          = halfField;
                halfReload_d       = halfField;
                pulseCnt_d         = pulseField - CNT_W'(1);
              end else begin
                done_d = 1'b1;
              end
            end
            default: ctrl_d = ctrl_q;
          endcase
        end
      end

      HIGH: begin
        dropped_d = store;
        if (halfCnt_q == '0) begin
          state_d            = LOW;
          ctrl_d[CLK_SH_BIT] = 1'b0;
          halfCnt_d          = halfReload_q;
        end else begin
          halfCnt_d = halfCnt_q - DIV_W'(1);
        end
      end

      LOW: begin
        dropped_d = store;
        // pulseCnt_q counts the pulses still owed after the one now finishing.
        if (halfCnt_q == '0) begin
          if (pulseCnt_q != '0) begin
            state_d            = HIGH;
            ctrl_d[CLK_SH_BIT] = 1'b1;
            halfCnt_d          = halfReload_q;
            pulseCnt_d         = pulseCnt_q - CNT_W'(1);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          halfCnt_d = halfCnt_q - DIV_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || pmcc_rst) begin
      state_q      <= IDLE;
      ctrl_q       <= '0;
      halfCnt_q    <= '0;
      halfReload_q <= '0;
      pulseCnt_q   <= '0;
      done_q       <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      halfCnt_q    <= halfCnt_d;
      halfReload_q <= halfReload_d;
      pulseCnt_q   <= pulseCnt_d;
      done_q       <= done_d;
      dropped_q    <= dropped_d;
    end
  end

  assign ctrl_word   = ctrl_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign cmd_dropped = dropped_q;

endmodule

// File: tb/tb_pmcc_matrix_sequencer.sv
// Scoreboard bench for pmcc_matrix_sequencer. A time-based reference model predicts each cycle's
// outputs, and a monitor pops those predictions and compares them against the DUT.
module tb_pmcc_matrix_sequencer;

  localparam int CTRL_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              pmcc_rst = 1'b0;
  logic              store = 1'b0;
  logic [31:0]       instr = '0;
  logic [CTRL_W-1:0] ctrl_word;
  logic              busy, done, cmd_dropped;

  pmcc_matrix_sequencer dut (
    .clk(clk), .rst(rst), .pmcc_rst(pmcc_rst), .store(store), .instr(instr),
    .ctrl_word(ctrl_word), .busy(busy), .done(done), .cmd_dropped(cmd_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic              busy;
    logic              done;
    logic              drop;
    int                edgeNo;
  } expT;

  expT expQ[$];

  int checks = 0;
  int failures = 0;

  // Reference model state: the train is described by its start edge, N and H,
  // and clkSh is derived from elapsed time rather than counters.
  int                edgeNo = 0;
  logic [CTRL_W-1:0] baseCtrl = '0;
  logic              prevBusy = 1'b0;
  bit                trainOn = 0;
  int                t0 = 0, nP = 0, hP = 1;

  int  busyCycles = 0;
  int  rises = 0;
  int  doneCount = 0;
  logic prevClkSh = 1'b0;

  task automatic modelEdge(input logic r, input logic s, input logic [31:0] ins);
    logic [CTRL_W-1:0] d, ec;
    logic eb, ed, edr, phase;
    int rel;
    expT item;
    eb = 0; ed = 0; edr = 0; phase = 0;
    if (r) begin
      baseCtrl = '0;
      trainOn  = 0;
    end else begin
      if (s && prevBusy) begin
        edr = 1;
      end else if (s) begin
        d = ins[8 +: CTRL_W];
        case (ins[31:30])
          2'd0: baseCtrl = d;
          2'd1: baseCtrl = baseCtrl | d;
          2'd2: baseCtrl = baseCtrl & ~d;
          default: begin
            nP = int'(ins[15:8]);
            hP = int'(ins[19:16]) + 1;
            if (nP == 0) ed = 1;
            else begin
              trainOn = 1;
              t0 = edgeNo;
            end
          end
        endcase
      end
      if (trainOn) begin
        rel = edgeNo - t0 + 1;
        if (rel <= 2 * nP * hP) begin
          eb = 1;
          phase = (((rel - 1) / hP) % 2) == 0;
        end else begin
          trainOn = 0;
          ed = 1;
          baseCtrl[0] = 1'b0;
        end
      end
    end
    ec = baseCtrl;
    if (eb) ec[0] = phase;
    prevBusy = eb;
    item.ctrl = ec; item.busy = eb; item.done = ed; item.drop = edr; item.edgeNo = edgeNo;
    expQ.push_back(item);
    edgeNo++;
  endtask

  task automatic applyStimulus(input logic r, input logic pr, input logic s, input logic [31:0] ins);
    rst = r; pmcc_rst = pr; store = s; instr = ins;
    @(posedge clk);
    modelEdge(r | pr, s, ins);
    #1;
    rst = 1'b0; pmcc_rst = 1'b0; store = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, $urandom);
  endtask

  task automatic checkOutput(input expT e);
    checks++;
    if ({ctrl_word, busy, done, cmd_dropped} !== {e.ctrl, e.busy, e.done, e.drop}) begin
      failures++;
      $display("[TB] FAIL edge%0d: got ctrl=%h busy=%b done=%b drop=%b, want ctrl=%h busy=%b done=%b drop=%b",
               e.edgeNo, ctrl_word, busy, done, cmd_dropped, e.ctrl, e.busy, e.done, e.drop);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
      if (busy) busyCycles++;
      if (done) doneCount++;
      if (ctrl_word[0] && !prevClkSh) rises++;
      prevClkSh = ctrl_word[0];
    end
  end

  initial begin
    logic [1:0] op;
    logic [31:0] ins;
    $display("[TB] start");

    applyStimulus(1'b1, 1'b0, 1'b1, 32'h00FFFF00);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h00FFFF00);
    idle(1);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000A500);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h40030000);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h80000500);
    idle(1);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h00000600);
    @(negedge clk); #1;
    doneCount = 0; busyCycles = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hC0010300);
    idle(14);
    @(negedge clk); #1;
    checkCount("train3_busy", busyCycles, 12);
    checkCount("train3_done", doneCount, 1);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'hC0050000);
    idle(2);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'hC0020200);
    idle(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h00FFFF00);
    idle(8);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h4000F000);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h00001200);
    idle(2);

    @(negedge clk); #1;
    doneCount = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hC0010400);
    idle(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    idle(20);
    @(negedge clk); #1;
    checkCount("abort_no_done", doneCount, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h00003300);
    idle(1);

    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      op = ins[31:30];
      if (op == 2'b11) ins[15:8] = 8'($urandom_range(0, 4));
      applyStimulus(1'b0, ($urandom_range(0, 60) == 0), ($urandom_range(0, 3) == 0), ins);
    end
    idle(200);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000F000);
    @(negedge clk); #1;
    rises = 0; busyCycles = 0; doneCount = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hC00FFF00);
    idle(8165);
    @(negedge clk); #1;
    checkCount("long_rises", rises, 255);
    checkCount("long_busy", busyCycles, 8160);
    checkCount("long_done", doneCount, 1);

    @(negedge clk); #1;
    checkCount("queue_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
